param_decode: RTL and testbench
===============================

PARAM_DECODE -- requirements
Module: param_decode

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/immediate data width.
REQ-002 SHALL have parameter NREG, default 16, register count; RAW=$clog2(NREG) address width.
REQ-003 SHALL have parameter PCW, default 5, program-counter width.
REQ-004 SHALL have parameter NHAZ, default 3, number of downstream writer stages checked for RAW (index 0 = youngest).
REQ-005 SHALL have ports: clk in 1 clock; rst in 1 reset, synchronous, active-low.
REQ-006 SHALL have ports: in_valid in 1; in_ready out 1; instr in 32; pc_in in PCW.
REQ-007 SHALL have ports: rf_addr_a, rf_addr_b out RAW; rf_data_a, rf_data_b in XLEN (combinational register-file read).
REQ-008 SHALL have ports: haz_valid in NHAZ; haz_addr in NHAZ*RAW; haz_data in NHAZ*XLEN; haz_data_ok in NHAZ (data available for bypass).
REQ-009 SHALL have ports: out_valid out 1; out_ready in 1; opcode out 5; data_a, data_b, immediate out XLEN; dest_addr out RAW; src_a out RAW; isimmediate out 1; pc out PCW.
REQ-010 SHALL have ports: jump_flag out 1; jump_dest out PCW; stall out 1.

Function
REQ-011 SHALL hold one instruction in holding register IR (ir_valid); fields per package: OP[31:27], IMM[26], Rd[25:22], Ra[21:18], Rb[17:14], IMM18[17:0], DISPL[4:0].
REQ-012 SHALL assert in_ready = !ir_valid | ir_advance, except 0 in the cycle a JMP advances.
REQ-013 SHALL drive rf_addr_a=Ra, rf_addr_b=Rb from IR combinationally; Rb is ignored for hazard when IMM=1.
REQ-014 SHALL flag a hazard on source s against stage k when haz_valid[k] and haz_addr[k]==s; the lowest matching k wins.
REQ-015 SHALL assert stall combinationally when ir_valid and any source has an unresolved hazard; IR then holds, out_valid goes 0 at the next edge (bubble, opcode NOP).
REQ-016 SHALL advance IR (ir_advance) when ir_valid, no stall, and (!out_valid | out_ready); output registers load at that edge, giving 1-cycle IR-to-output latency.
REQ-017 SHALL hold all outputs stable while out_valid=1 and out_ready=0.
REQ-018 SHALL sign-extend IMM18 to XLEN for immediate when IMM=1, else immediate=0; data_b=0 when IMM=1.
REQ-019 SHALL resolve JMP in this stage: jump_dest=DISPL zero-extended when IMM=1, else (pc+DISPL) mod 2^PCW; jump_flag=1 for exactly one cycle after the advancing edge; no out_valid for the JMP.
REQ-020 SHALL, on JMP advance, discard IR and refuse input that cycle (flush).
REQ-021 SHALL treat in_valid with IR full and no advance as not accepted; the upstream holds instr.

Reset
REQ-022 SHALL, at a clk edge with rst=0, clear ir_valid, out_valid, jump_flag, and set opcode=NOP, data/immediate/pc/jump_dest/dest_addr/src_a=0, isimmediate=0, regardless of operation in progress.
REQ-023 SHALL hold in_ready=0 and stall=0 while rst=0.

Configuration
REQ-024 SHALL compile bypassing under DECODE_FWD_EN: a matched hazard with haz_data_ok[k]=1 is resolved by selecting haz_data[k] instead of rf_data, no stall; only haz_data_ok[k]=0 stalls.
REQ-025 SHALL, without DECODE_FWD_EN, stall on every matched hazard; haz_data/haz_data_ok are ignored.

Structure
REQ-026 SHALL take opcode constants (NOP=0, JMP), field ranges and the NOP encoding from the shared package pigro_pkg.
REQ-027 SHALL instantiate one sub-module, hazard_unit (parametrised NHAZ/RAW/XLEN), containing match, priority and bypass select.

Verification
REQ-028 SHALL cover: ADD R3,R1,R2 with no hazards, out_ready=1 -> out_valid one cycle after IR load, data_a=rf_data_a, dest_addr=3.
REQ-029 SHALL cover: Ra=1, haz_valid[0]=1, haz_addr[0]=1 for 2 cycles -> stall=1, out_valid=0 twice, then issue with fresh data.
REQ-030 SHALL cover: JMP IMM=0, pc=30, DISPL=5 -> jump_flag pulse, jump_dest=3, concurrent input not accepted, no out_valid.
REQ-031 SHALL cover: IMM=1, IMM18=0x3FFFF -> immediate=all-ones (XLEN=32 and XLEN=16 builds).
REQ-032 SHALL cover: out_ready=0 for 3 cycles with full IR -> outputs stable, in_ready=0; rst=0 mid-stall -> all outputs at reset values.
REQ-033 SHALL cover: DECODE_FWD_EN, haz_addr[1]=Ra, haz_data_ok[1]=1, haz_data=0x55 -> no stall, data_a=0x55.

Source files
------------

// File: rtl/pigro_pkg.sv
// Shared decode definitions: opcodes, instruction field layout
// and the NOP encoding used by the decode stage.
package pigro_pkg;

  typedef enum logic [4:0] {
    OP_NOP  = 5'd0,
    OP_ADD  = 5'd2,
    OP_ADDI = 5'd3,
    OP_JMP  = 5'd16
  } op_e;

  // OP[31:27] IMM[26] Rd[25:22] Ra[21:18] Rb[17:14], low bits follow
  typedef struct packed {
    logic [4:0]  op;
    logic        imm;
    logic [3:0]  rd;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [13:0] lo;
  } instr_t;

  localparam logic [31:0] NOP_INSTR = 32'h0;

  function automatic logic [17:0] f_imm18(instr_t i);
    return {i.rb, i.lo};
  endfunction

  function automatic logic [4:0] f_displ(instr_t i);
    return i.lo[4:0];
  endfunction

endpackage

// File: rtl/param_decode_hazard_unit.sv
// RAW match against downstream writers, lowest index wins.
// DECODE_FWD_EN turns matched, ready writers into bypass sources.
module hazard_unit
  import pigro_pkg::*;
#(
  parameter int NHAZ = 3,
  parameter int RAW  = 4,
  parameter int XLEN = 32
) (
  input  logic [NHAZ-1:0]      i_haz_valid,
  input  logic [NHAZ*RAW-1:0]  i_haz_addr,
  input  logic [NHAZ*XLEN-1:0] i_haz_data,
  input  logic [NHAZ-1:0]      i_haz_data_ok,
  input  logic [RAW-1:0]       i_addr_a,
  input  logic [RAW-1:0]       i_addr_b,
  input  logic                 i_use_b,
  input  logic [XLEN-1:0]      i_rf_a,
  input  logic [XLEN-1:0]      i_rf_b,
  output logic                 o_hazard,
  output logic [XLEN-1:0]      o_data_a,
  output logic [XLEN-1:0]      o_data_b
);

  logic            w_hit_a, w_hit_b;
  logic            w_ok_a, w_ok_b;
  logic [XLEN-1:0] w_byp_a, w_byp_b;

  // Scan oldest to youngest so the youngest match overwrites
  always_comb begin
    w_hit_a = 1'b0;
    w_hit_b = 1'b0;
    w_ok_a  = 1'b0;
    w_ok_b  = 1'b0;
    w_byp_a = '0;
    w_byp_b = '0;
    for (int k = NHAZ - 1; k >= 0; k--) begin
      if (i_haz_valid[k] &&
          i_haz_addr[k*RAW +: RAW] == i_addr_a) begin
        w_hit_a = 1'b1;
        w_ok_a  = i_haz_data_ok[k];
        w_byp_a = i_haz_data[k*XLEN +: XLEN];
      end
      if (i_use_b && i_haz_valid[k] &&
          i_haz_addr[k*RAW +: RAW] == i_addr_b) begin
        w_hit_b = 1'b1;
        w_ok_b  = i_haz_data_ok[k];
        w_byp_b = i_haz_data[k*XLEN +: XLEN];
      end
    end
  end

`ifdef DECODE_FWD_EN
  assign o_hazard = (w_hit_a & ~w_ok_a) |
                    (w_hit_b & ~w_ok_b);
  assign o_data_a = w_hit_a ? w_byp_a : i_rf_a;
  assign o_data_b = w_hit_b ? w_byp_b : i_rf_b;
`else
  logic w_unused;
  assign w_unused = ^{i_haz_data, i_haz_data_ok,
                      w_ok_a, w_ok_b, w_byp_a, w_byp_b};
  assign o_hazard = w_hit_a | w_hit_b;
  assign o_data_a = i_rf_a;
  assign o_data_b = i_rf_b;
`endif

endmodule

// File: rtl/param_decode.sv
// Decode stage: one-entry IR, RAW stall/bypass, in-stage JMP.
// Build with DECODE_FWD_EN to bypass ready downstream results.
module param_decode
  import pigro_pkg::*;
#(
  parameter  int XLEN = 32,
  parameter  int NREG = 16,
  parameter  int PCW  = 5,
  parameter  int NHAZ = 3,
  localparam int RAW  = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          instr,
  input  logic [PCW-1:0]       pc_in,
  output logic [RAW-1:0]       rf_addr_a,
  output logic [RAW-1:0]       rf_addr_b,
  input  logic [XLEN-1:0]      rf_data_a,
  input  logic [XLEN-1:0]      rf_data_b,
  input  logic [NHAZ-1:0]      haz_valid,
  input  logic [NHAZ*RAW-1:0]  haz_addr,
  input  logic [NHAZ*XLEN-1:0] haz_data,
  input  logic [NHAZ-1:0]      haz_data_ok,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4:0]           opcode,
  output logic [XLEN-1:0]      data_a,
  output logic [XLEN-1:0]      data_b,
  output logic [XLEN-1:0]      immediate,
  output logic [RAW-1:0]       dest_addr,
  output logic [RAW-1:0]       src_a,
  output logic                 isimmediate,
  output logic [PCW-1:0]       pc,
  output logic                 jump_flag,
  output logic [PCW-1:0]       jump_dest,
  output logic                 stall
);

  instr_t           r_ir;
  logic             r_ir_valid;
  logic [PCW-1:0]   r_ir_pc;
  logic             r_out_valid;
  logic [4:0]       r_op;
  logic [XLEN-1:0]  r_da, r_db, r_imm;
  logic [RAW-1:0]   r_dest, r_src;
  logic             r_isimm;
  logic [PCW-1:0]   r_pc;
  logic             r_jflag;
  logic [PCW-1:0]   r_jdest;

  logic [RAW-1:0]     w_ra, w_rb, w_rd;
  logic               w_imm, w_jmp, w_hz;
  logic               w_stall, w_adv, w_in_ready;
  logic [XLEN-1:0]    w_da, w_db, w_sext;
  logic signed [17:0] w_i18;
  logic [PCW-1:0]     w_displ, w_jdest;

  assign w_ra  = RAW'(r_ir.ra);
  assign w_rb  = RAW'(r_ir.rb);
  assign w_rd  = RAW'(r_ir.rd);
  assign w_imm = r_ir.imm;
  assign w_jmp = (r_ir.op == OP_JMP);

  assign rf_addr_a = w_ra;
  assign rf_addr_b = w_rb;

  hazard_unit #(
    .NHAZ (NHAZ),
    .RAW  (RAW),
    .XLEN (XLEN)
  ) u_hazard (
    .i_haz_valid   (haz_valid),
    .i_haz_addr    (haz_addr),
    .i_haz_data    (haz_data),
    .i_haz_data_ok (haz_data_ok),
    .i_addr_a      (w_ra),
    .i_addr_b      (w_rb),
    .i_use_b       (~w_imm),
    .i_rf_a        (rf_data_a),
    .i_rf_b        (rf_data_b),
    .o_hazard      (w_hz),
    .o_data_a      (w_da),
    .o_data_b      (w_db)
  );

  assign w_stall = rst & r_ir_valid & w_hz;
  assign w_adv   = r_ir_valid & ~w_stall &
                   (~r_out_valid | out_ready);
  // A jump flushes its own slot, so nothing enters behind it
  assign w_in_ready = rst & (~r_ir_valid | w_adv) &
                      ~(w_adv & w_jmp);

  assign w_i18   = f_imm18(r_ir);
  assign w_sext  = XLEN'(w_i18);
  assign w_displ = PCW'(f_displ(r_ir));
  assign w_jdest = w_imm ? w_displ : r_ir_pc + w_displ;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ir        <= NOP_INSTR;
      r_ir_valid  <= 1'b0;
      r_ir_pc     <= '0;
      r_out_valid <= 1'b0;
      r_op        <= OP_NOP;
      r_da        <= '0;
      r_db        <= '0;
      r_imm       <= '0;
      r_dest      <= '0;
      r_src       <= '0;
      r_isimm     <= 1'b0;
      r_pc        <= '0;
      r_jflag     <= 1'b0;
      r_jdest     <= '0;
    end else begin
      r_jflag <= w_adv & w_jmp;
      if (in_valid && w_in_ready) begin
        r_ir       <= instr;
        r_ir_pc    <= pc_in;
        r_ir_valid <= 1'b1;
      end else if (w_adv) begin
        r_ir_valid <= 1'b0;
      end
      if (w_adv && w_jmp) begin
        r_jdest     <= w_jdest;
        r_out_valid <= 1'b0;
        r_op        <= OP_NOP;
      end else if (w_adv) begin
        r_out_valid <= 1'b1;
        r_op        <= r_ir.op;
        r_da        <= w_da;
        r_db        <= w_imm ? '0 : w_db;
        r_imm       <= w_imm ? w_sext : '0;
        r_dest      <= w_rd;
        r_src       <= w_ra;
        r_isimm     <= w_imm;
        r_pc        <= r_ir_pc;
      end else if (!r_out_valid || out_ready) begin
        r_out_valid <= 1'b0;
        r_op        <= OP_NOP;
      end
    end
  end

  assign in_ready    = w_in_ready;
  assign stall       = w_stall;
  assign out_valid   = r_out_valid;
  assign opcode      = r_op;
  assign data_a      = r_da;
  assign data_b      = r_db;
  assign immediate   = r_imm;
  assign dest_addr   = r_dest;
  assign src_a       = r_src;
  assign isimmediate = r_isimm;
  assign pc          = r_pc;
  assign jump_flag   = r_jflag;
  assign jump_dest   = r_jdest;

endmodule

// File: tb/tb_param_decode.sv
// Scoreboarded bench for param_decode; TB_XLEN16 selects XLEN=16,
// DECODE_FWD_EN selects the bypass scenario.
module tb_param_decode;
  import pigro_pkg::*;

`ifdef TB_XLEN16
  localparam int XLEN = 16;
`else
  localparam int XLEN = 32;
`endif
  localparam int NREG = 16;
  localparam int RAW  = 4;
  localparam int PCW  = 5;
  localparam int NHAZ = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [31:0]          instr = '0;
  logic [PCW-1:0]       pc_in = '0;
  logic [RAW-1:0]       rf_addr_a, rf_addr_b;
  logic [XLEN-1:0]      rf_data_a, rf_data_b;
  logic [NHAZ-1:0]      haz_valid = '0;
  logic [NHAZ*RAW-1:0]  haz_addr = '0;
  logic [NHAZ*XLEN-1:0] haz_data = '0;
  logic [NHAZ-1:0]      haz_data_ok = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [4:0]           opcode;
  logic [XLEN-1:0]      data_a, data_b, immediate;
  logic [RAW-1:0]       dest_addr, src_a;
  logic                 isimmediate;
  logic [PCW-1:0]       pc;
  logic                 jump_flag;
  logic [PCW-1:0]       jump_dest;
  logic                 stall;

  logic [XLEN-1:0] rf_mem [NREG];
  assign rf_data_a = rf_mem[rf_addr_a];
  assign rf_data_b = rf_mem[rf_addr_b];

  param_decode #(
    .XLEN (XLEN), .NREG (NREG), .PCW (PCW), .NHAZ (NHAZ)
  ) dut (
    .clk (clk), .rst (rst),
    .in_valid (in_valid), .in_ready (in_ready),
    .instr (instr), .pc_in (pc_in),
    .rf_addr_a (rf_addr_a), .rf_addr_b (rf_addr_b),
    .rf_data_a (rf_data_a), .rf_data_b (rf_data_b),
    .haz_valid (haz_valid), .haz_addr (haz_addr),
    .haz_data (haz_data), .haz_data_ok (haz_data_ok),
    .out_valid (out_valid), .out_ready (out_ready),
    .opcode (opcode), .data_a (data_a), .data_b (data_b),
    .immediate (immediate), .dest_addr (dest_addr),
    .src_a (src_a), .isimmediate (isimmediate), .pc (pc),
    .jump_flag (jump_flag), .jump_dest (jump_dest),
    .stall (stall)
  );

  typedef struct packed {
    logic [4:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] imm;
    logic [RAW-1:0]  dest;
    logic [RAW-1:0]  src;
    logic            isimm;
    logic [PCW-1:0]  pc;
  } exp_t;

  exp_t sb[$];
  int n_pass = 0;
  int n_total = 0;

  function automatic logic [31:0] enc(
    logic [4:0] op, logic im, logic [3:0] rd,
    logic [3:0] ra, logic [3:0] rb, logic [13:0] lo);
    return {op, im, rd, ra, rb, lo};
  endfunction

  // Reference decode of one instruction against the current rf_mem
  function automatic exp_t mk_exp(logic [31:0] ins, logic [PCW-1:0] p);
    exp_t e;
    logic im;
    logic [63:0] s;
    im = ins[26];
    s = {{46{ins[17]}}, ins[17:0]};
    e.op = ins[31:27];
    e.a = rf_mem[ins[21:18]];
    e.b = im ? '0 : rf_mem[ins[17:14]];
    e.imm = im ? s[XLEN-1:0] : '0;
    e.dest = ins[25:22];
    e.src = ins[21:18];
    e.isimm = im;
    e.pc = p;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t g, e;
    if (rst && out_valid && out_ready) begin
      g = {opcode, data_a, data_b, immediate,
           dest_addr, src_a, isimmediate, pc};
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL sb_empty: got %h expected none", g);
      end else begin
        e = sb.pop_front();
        if (g !== e) $display("FAIL sb_out: got %h expected %h", g, e);
        else n_pass++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins, input logic [PCW-1:0] p);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1;
    instr = ins;
    pc_in = p;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      if (acc) break;
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_total++;
      $display("FAIL send_timeout: got in_ready 0 expected 1");
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    n_total++; if (out_valid !== 1'b0) $display("FAIL rst_ov: got %b expected 0", out_valid); else n_pass++;
    n_total++; if (opcode !== OP_NOP) $display("FAIL rst_op: got %h expected 0", opcode); else n_pass++;
    n_total++; if (jump_flag !== 1'b0) $display("FAIL rst_jf: got %b expected 0", jump_flag); else n_pass++;
    n_total++; if (in_ready !== 1'b0) $display("FAIL rst_ir: got %b expected 0", in_ready); else n_pass++;
    n_total++; if (stall !== 1'b0) $display("FAIL rst_st: got %b expected 0", stall); else n_pass++;
    rst = 1'b1;
    tick();
    n_total++; if (in_ready !== 1'b1) $display("FAIL rst_rel: got %b expected 1", in_ready); else n_pass++;
  endtask

  task automatic test_add();
    logic [31:0] ins;
    out_ready = 1'b1;
    ins = enc(OP_ADD, 1'b0, 4'd3, 4'd1, 4'd2, 14'd0);
    sb.push_back(mk_exp(ins, 5'd7));
    send(ins, 5'd7);
    n_total++; if (out_valid !== 1'b0) $display("FAIL add_lat: got %b expected 0", out_valid); else n_pass++;
    n_total++; if (rf_addr_a !== 4'd1) $display("FAIL add_rfa: got %h expected 1", rf_addr_a); else n_pass++;
    tick();
    n_total++; if (out_valid !== 1'b1) $display("FAIL add_ov: got %b expected 1", out_valid); else n_pass++;
    n_total++; if (data_a !== rf_mem[1]) $display("FAIL add_da: got %h expected %h", data_a, rf_mem[1]); else n_pass++;
    n_total++; if (dest_addr !== 4'd3) $display("FAIL add_rd: got %h expected 3", dest_addr); else n_pass++;
    tick();
    n_total++; if (out_valid !== 1'b0) $display("FAIL add_drop: got %b expected 0", out_valid); else n_pass++;
  endtask

  task automatic test_hazard_stall();
    logic [31:0] ins;
    out_ready = 1'b1;
    haz_valid = 3'b001;
    haz_addr = {4'd0, 4'd0, 4'd1};
    ins = enc(OP_ADD, 1'b0, 4'd4, 4'd1, 4'd5, 14'd0);
    send(ins, 5'd8);
    n_total++; if (stall !== 1'b1) $display("FAIL hz_st0: got %b expected 1", stall); else n_pass++;
    n_total++; if (in_ready !== 1'b0) $display("FAIL hz_ir: got %b expected 0", in_ready); else n_pass++;
    tick();
    n_total++; if (out_valid !== 1'b0) $display("FAIL hz_ov1: got %b expected 0", out_valid); else n_pass++;
    n_total++; if (opcode !== OP_NOP) $display("FAIL hz_nop: got %h expected 0", opcode); else n_pass++;
    tick();
    n_total++; if (out_valid !== 1'b0) $display("FAIL hz_ov2: got %b expected 0", out_valid); else n_pass++;
    rf_mem[1] = XLEN'(32'h5A5A_C3C3);
    haz_valid = '0;
    sb.push_back(mk_exp(ins, 5'd8));
    #1;
    n_total++; if (stall !== 1'b0) $display("FAIL hz_rel: got %b expected 0", stall); else n_pass++;
    tick();
    n_total++; if (out_valid !== 1'b1) $display("FAIL hz_iss: got %b expected 1", out_valid); else n_pass++;
    n_total++; if (data_a !== XLEN'(32'h5A5A_C3C3)) $display("FAIL hz_fresh: got %h expected %h", data_a, XLEN'(32'h5A5A_C3C3)); else n_pass++;
    tick();
  endtask

  task automatic test_jmp();
    logic [31:0] j, a;
    out_ready = 1'b1;
    j = enc(OP_JMP, 1'b0, 4'd0, 4'd0, 4'd0, 14'd5);
    a = enc(OP_ADD, 1'b0, 4'd6, 4'd2, 4'd3, 14'd0);
    send(j, 5'd30);
    in_valid = 1'b1;
    instr = a;
    pc_in = 5'd9;
    #1;
    n_total++; if (in_ready !== 1'b0) $display("FAIL jmp_ir: got %b expected 0", in_ready); else n_pass++;
    tick();
    n_total++; if (jump_flag !== 1'b1) $display("FAIL jmp_jf: got %b expected 1", jump_flag); else n_pass++;
    n_total++; if (jump_dest !== 5'd3) $display("FAIL jmp_dst: got %h expected 3", jump_dest); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL jmp_ov: got %b expected 0", out_valid); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL jmp_ir2: got %b expected 1", in_ready); else n_pass++;
    tick();
    in_valid = 1'b0;
    sb.push_back(mk_exp(a, 5'd9));
    n_total++; if (jump_flag !== 1'b0) $display("FAIL jmp_pulse: got %b expected 0", jump_flag); else n_pass++;
    tick();
    n_total++; if (pc !== 5'd9) $display("FAIL jmp_next: got %h expected 9", pc); else n_pass++;
    tick();
    j = enc(OP_JMP, 1'b1, 4'd0, 4'd0, 4'd0, 14'd7);
    send(j, 5'd30);
    tick();
    n_total++; if (jump_dest !== 5'd7) $display("FAIL jmp_abs: got %h expected 7", jump_dest); else n_pass++;
    tick();
  endtask

  task automatic test_imm();
    logic [31:0] ins;
    logic [63:0] pos;
    out_ready = 1'b1;
    haz_valid = 3'b001;
    haz_addr = {4'd0, 4'd0, 4'd15};
    ins = enc(OP_ADDI, 1'b1, 4'd2, 4'd1, 4'hF, 14'h3FFF);
    sb.push_back(mk_exp(ins, 5'd4));
    send(ins, 5'd4);
    n_total++; if (stall !== 1'b0) $display("FAIL imm_rb: got %b expected 0", stall); else n_pass++;
    tick();
    n_total++; if (immediate !== {XLEN{1'b1}}) $display("FAIL imm_neg: got %h expected all ones", immediate); else n_pass++;
    n_total++; if (data_b !== '0) $display("FAIL imm_db: got %h expected 0", data_b); else n_pass++;
    haz_valid = '0;
    ins = enc(OP_ADDI, 1'b1, 4'd2, 4'd1, 4'h7, 14'h3FFF);
    pos = 64'h1_FFFF;
    sb.push_back(mk_exp(ins, 5'd5));
    send(ins, 5'd5);
    tick();
    n_total++; if (immediate !== pos[XLEN-1:0]) $display("FAIL imm_pos: got %h expected %h", immediate, pos[XLEN-1:0]); else n_pass++;
    tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b;
    exp_t ea;
    out_ready = 1'b0;
    a = enc(OP_ADD, 1'b0, 4'd1, 4'd2, 4'd3, 14'd0);
    b = enc(OP_ADD, 1'b0, 4'd5, 4'd6, 4'd7, 14'd0);
    ea = mk_exp(a, 5'd1);
    send(a, 5'd1);
    send(b, 5'd2);
    haz_valid = 3'b001;
    haz_addr = {4'd0, 4'd0, 4'd6};
    in_valid = 1'b1;
    instr = enc(OP_ADD, 1'b0, 4'd9, 4'd9, 4'd9, 14'd0);
    #1;
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if ({opcode, data_a, data_b, immediate, dest_addr, src_a, isimmediate, pc} !== ea || out_valid !== 1'b1)
        $display("FAIL bp_hold: got %h expected %h", {opcode, data_a, data_b, immediate, dest_addr, src_a, isimmediate, pc}, ea);
      else n_pass++;
      n_total++; if (in_ready !== 1'b0) $display("FAIL bp_ir: got %b expected 0", in_ready); else n_pass++;
      tick();
    end
    n_total++; if (stall !== 1'b1) $display("FAIL bp_st: got %b expected 1", stall); else n_pass++;
    rst = 1'b0;
    #1;
    n_total++; if (in_ready !== 1'b0 || stall !== 1'b0) $display("FAIL rst_comb: got %b%b expected 00", in_ready, stall); else n_pass++;
    tick();
    n_total++;
    if ({out_valid, jump_flag, isimmediate} !== 3'b000 || opcode !== OP_NOP ||
        data_a !== '0 || data_b !== '0 || immediate !== '0 || pc !== '0 ||
        jump_dest !== '0 || dest_addr !== '0 || src_a !== '0)
      $display("FAIL rst_mid: got ov%b op%h a%h b%h i%h pc%h jd%h rd%h expected zeros",
               out_valid, opcode, data_a, data_b, immediate, pc, jump_dest, dest_addr);
    else n_pass++;
    in_valid = 1'b0;
    haz_valid = '0;
    sb.delete();
    rst = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    n_total++; if (out_valid !== 1'b0) $display("FAIL rst_ir_clr: got %b expected 0", out_valid); else n_pass++;
  endtask

  task automatic test_fwd();
    logic [31:0] ins;
    exp_t e;
    out_ready = 1'b1;
    ins = enc(OP_ADD, 1'b0, 4'd8, 4'd6, 4'd9, 14'd0);
`ifdef DECODE_FWD_EN
    haz_valid = 3'b110;
    haz_addr = {4'd6, 4'd6, 4'd0};
    haz_data_ok = 3'b010;
    haz_data = {XLEN'(0), XLEN'(32'h55), XLEN'(0)};
    e = mk_exp(ins, 5'd3);
    e.a = XLEN'(32'h55);
    sb.push_back(e);
    send(ins, 5'd3);
    n_total++; if (stall !== 1'b0) $display("FAIL fwd_st: got %b expected 0", stall); else n_pass++;
    tick();
    n_total++; if (data_a !== XLEN'(32'h55)) $display("FAIL fwd_da: got %h expected 55", data_a); else n_pass++;
    haz_valid = 3'b011;
    haz_addr = {4'd0, 4'd6, 4'd6};
    haz_data_ok = 3'b011;
    haz_data = {XLEN'(0), XLEN'(32'h55), XLEN'(32'h77)};
    e.a = XLEN'(32'h77);
    sb.push_back(e);
    send(ins, 5'd3);
    tick();
    n_total++; if (data_a !== XLEN'(32'h77)) $display("FAIL fwd_prio: got %h expected 77", data_a); else n_pass++;
    haz_valid = 3'b001;
    haz_data_ok = 3'b000;
    send(ins, 5'd3);
    n_total++; if (stall !== 1'b1) $display("FAIL fwd_nok: got %b expected 1", stall); else n_pass++;
`else
    haz_valid = 3'b010;
    haz_addr = {4'd0, 4'd6, 4'd0};
    haz_data_ok = 3'b010;
    haz_data = {XLEN'(0), XLEN'(32'h55), XLEN'(0)};
    send(ins, 5'd3);
    n_total++; if (stall !== 1'b1) $display("FAIL nofwd_st: got %b expected 1", stall); else n_pass++;
    tick();
`endif
    e = mk_exp(ins, 5'd3);
    haz_valid = '0;
    haz_data_ok = '0;
    sb.push_back(e);
    tick();
    n_total++; if (data_a !== rf_mem[6]) $display("FAIL rel_da: got %h expected %h", data_a, rf_mem[6]); else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          logic [31:0] ins;
          ins = enc(OP_ADD, 1'b0, 4'(i), 4'(i + 1), 4'(15 - i), 14'(i));
          sb.push_back(mk_exp(ins, 5'(i + 10)));
          send(ins, 5'(i + 10));
        end
      end
      begin
        for (int j = 0; j < 40; j++) begin
          out_ready = 1'($urandom_range(0, 1));
          tick();
        end
        out_ready = 1'b1;
      end
    join
    for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
    n_total++; if (sb.size() != 0) $display("FAIL b2b_drain: got %0d pending expected 0", sb.size()); else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NREG; i++)
      rf_mem[i] = XLEN'(32'hA000 + i * 32'h111);
    test_reset();
    test_add();
    test_hazard_stall();
    test_jmp();
    test_imm();
    test_backpressure();
    test_fwd();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
